// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared IDs, FSM state encodings and fixed AXI field values
package axi_arb_pkg;

   localparam logic [3:0] INST_ID_DEF = 4'd0;
   localparam logic [3:0] DATA_ID_DEF = 4'd1;

   localparam logic [3:0] AX_LEN   = 4'd0;
   localparam logic [2:0] AX_SIZE  = 3'b010;
   localparam logic [1:0] AX_BURST = 2'b01;

   typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;

endpackage

// File: rtl/axi_write_channel.sv
// rtl/axi_write_channel.sv - single-beat store FSM; AW and W handshakes tracked independently
module axi_write_channel
   import axi_arb_pkg::*;
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        data_wen,
   input  logic        allow,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wsel,
   output logic        gnt,
   output logic        idle,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready,
   output logic        bdone
);

   w_state_t state, next;
   logic     aw_done, w_done, aw_hs, w_hs;

   assign gnt     = (state == W_IDLE) && data_wen && allow;
   assign idle    = (state == W_IDLE);
   assign awvalid = (state == W_ADDR) && !aw_done;
   assign wvalid  = (state == W_ADDR) && !w_done;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign bready  = (state == W_RESP);
   assign bdone   = bready && bvalid;

   always_comb begin
      next = state;
      case (state)
         W_IDLE:  if (gnt) next = W_ADDR;
         W_ADDR:  if ((aw_done || aw_hs) && (w_done || w_hs)) next = W_RESP;
         W_RESP:  if (bvalid) next = W_IDLE;
         default: next = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= W_IDLE;
         awaddr  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state <= next;
         // Flags are only meaningful in W_ADDR; they restart on each accepted store.
         if (gnt) begin
            awaddr  <= data_addr;
            wdata   <= data_wdata;
            wstrb   <= data_wsel;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_req_arbiter.sv
// rtl/axi_req_arbiter.sv - AXI3 master sequencer for fetch and load/store requesters
// Optional: AXI_ARB_ROUND_ROBIN_EN selects round-robin read arbitration (default data-first).
module axi_req_arbiter
   import axi_arb_pkg::*;
#(
   parameter logic [3:0] INST_ID = INST_ID_DEF,
   parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        flush,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_gnt,
   output logic [31:0] inst_rdata,
   output logic        inst_rvalid,
   input  logic        data_ren,
   input  logic        data_wen,
   input  logic [3:0]  data_wsel,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic [31:0] data_rdata,
   output logic        data_rvalid,
   output logic        data_bvalid,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   r_state_t    r_state, r_next;
   logic [31:0] r_addr;
   logic [3:0]  r_id;
   logic        drop;
   logic        rd_done, can_sel, inst_cand, data_cand, sel_inst, sel_data;
   logic        w_idle, w_gnt, wr_allow;

   // A completing read frees the port, so the next read may be selected in that same cycle.
   assign rd_done   = (r_state == R_R) && rvalid;
   assign can_sel   = (r_state == R_IDLE) || rd_done;
   assign inst_cand = can_sel && inst_req && !flush;
   assign data_cand = can_sel && data_ren && !data_wen && w_idle;

`ifdef AXI_ARB_ROUND_ROBIN_EN
   logic last_data;

   assign sel_data = data_cand && (!inst_cand || !last_data);
   assign sel_inst = inst_cand && !sel_data;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                 last_data <= 1'b0;
      else if (sel_data || sel_inst) last_data <= sel_data;
   end
`else
   assign sel_data = data_cand;
   assign sel_inst = inst_cand && !data_cand;
`endif

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (sel_inst || sel_data) r_next = R_AR;
         R_AR:    if (arready) r_next = R_R;
         R_R:     if (rvalid) r_next = (sel_inst || sel_data) ? R_AR : R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= R_IDLE;
         r_addr  <= '0;
         r_id    <= INST_ID;
         drop    <= 1'b0;
      end else begin
         r_state <= r_next;
         if (sel_inst) begin
            r_addr <= inst_addr;
            r_id   <= INST_ID;
         end else if (sel_data) begin
            r_addr <= data_addr;
            r_id   <= DATA_ID;
         end
         // Flush never coincides with an inst grant, so only an in-flight fetch can be dropped.
         if (rd_done)
            drop <= 1'b0;
         else if (flush && (r_state != R_IDLE) && (r_id == INST_ID))
            drop <= 1'b1;
      end
   end

   assign arvalid     = (r_state == R_AR);
   assign araddr      = r_addr;
   assign arid        = r_id;
   assign rready      = (r_state == R_R);
   assign inst_rvalid = rvalid && rready && (rid == INST_ID) && !drop;
   assign data_rvalid = rvalid && rready && (rid == DATA_ID);
   assign inst_rdata  = rdata;
   assign data_rdata  = rdata;
   assign inst_gnt    = sel_inst;
   assign data_gnt    = sel_data || w_gnt;

   // Stores may overlap a fetch but never an outstanding load.
   assign wr_allow = (r_state == R_IDLE) || (r_id == INST_ID);

   axi_write_channel u_wr (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .data_wen   (data_wen),
      .allow      (wr_allow),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_wsel  (data_wsel),
      .gnt        (w_gnt),
      .idle       (w_idle),
      .awaddr     (awaddr),
      .awvalid    (awvalid),
      .awready    (awready),
      .wdata      (wdata),
      .wstrb      (wstrb),
      .wvalid     (wvalid),
      .wready     (wready),
      .bvalid     (bvalid),
      .bready     (bready),
      .bdone      (data_bvalid)
   );

   assign arlen   = AX_LEN;
   assign arsize  = AX_SIZE;
   assign arburst = AX_BURST;
   assign arlock  = '0;
   assign arcache = '0;
   assign arprot  = '0;
   assign awid    = DATA_ID;
   assign awlen   = AX_LEN;
   assign awsize  = AX_SIZE;
   assign awburst = AX_BURST;
   assign awlock  = '0;
   assign awcache = '0;
   assign awprot  = '0;
   assign wid     = DATA_ID;
   assign wlast   = 1'b1;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// tb/tb_axi_req_arbiter.sv - directed timing steps plus randomized traffic against a transaction model
module tb_axi_req_arbiter;

   localparam logic [3:0] IID = 4'd0;
   localparam logic [3:0] DID = 4'd1;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic        aresetn, flush, inst_req, inst_gnt, inst_rvalid;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_ren, data_wen, data_gnt, data_rvalid, data_bvalid;
   logic [3:0]  data_wsel;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  arid, rid, awid, wid, arlen, awlen, arcache, awcache, wstrb;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock;
   logic        arvalid, arready, rvalid, rready, awvalid, awready;
   logic        wlast, wvalid, wready, bvalid, bready;

   axi_req_arbiter dut (
      .aclk(aclk), .aresetn(aresetn), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
      .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
      .data_ren(data_ren), .data_wen(data_wen), .data_wsel(data_wsel),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
      .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_bvalid(data_bvalid),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   int total  = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic nxt();
      @(posedge aclk);
      #1;
   endtask

   // Transaction-level model: at most one read and one store outstanding.
   logic        rd_v, rd_ar, rd_drop, st_v, st_aw, st_w;
   logic [3:0]  rd_id;
   logic [31:0] rd_addr, st_addr, st_data;
   logic [3:0]  st_strb;
   logic        inst_clr, data_clr, gen;
   logic        rd_done, rd_free, st_busy, rd_busy_data, load_ok;

   initial begin
      aresetn = 1'b0; flush = 1'b0; inst_req = 1'b0; inst_addr = '0;
      data_ren = 1'b0; data_wen = 1'b0; data_wsel = '0; data_addr = '0; data_wdata = '0;
      arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, inst_gnt, data_gnt,
                         inst_rvalid, data_rvalid, data_bvalid}, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_wstrb", wstrb, 0);
      chk("const_fields", {arlen, arsize, arburst, awlen, awsize, awburst, wlast},
          {4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01, 1'b1});
      chk("const_zero", {arlock, arcache, arprot, awlock, awcache, awprot}, 0);
      aresetn = 1'b1;

      // Single fetch: grant N, arvalid N+1, response N+2
      nxt(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #1;
      chk("t1_gnt", {inst_gnt, data_gnt}, 2'b10);
      nxt(); inst_req = 1'b0; arready = 1'b1; #1;
      chk("t1_ar", {arvalid, arid}, {1'b1, IID});
      chk("t1_araddr", araddr, 32'hBFC0_0000);
      nxt(); arready = 1'b0; rvalid = 1'b1; rid = IID; rdata = 32'h3C08_0001; #1;
      chk("t1_resp", {rready, inst_rvalid, data_rvalid}, 3'b110);
      chk("t1_rdata", inst_rdata, 32'h3C08_0001);
      nxt(); rvalid = 1'b0; #1;
      chk("t1_idle", {arvalid, rready, inst_rvalid}, 0);

      // Tie: data read first, inst granted back-to-back on completion
      nxt(); inst_req = 1'b1; inst_addr = 32'hBFC0_0010; data_ren = 1'b1; data_addr = 32'h8000_0040; #1;
      chk("t2_gnt", {inst_gnt, data_gnt}, 2'b01);
      nxt(); data_ren = 1'b0; arready = 1'b1; #1;
      chk("t2_ar_data", {arvalid, arid}, {1'b1, DID});
      chk("t2_araddr_data", araddr, 32'h8000_0040);
      nxt(); arready = 1'b0; rvalid = 1'b1; rid = DID; rdata = 32'h1122_3344; #1;
      chk("t2_data_resp", {data_rvalid, inst_rvalid, inst_gnt}, 3'b101);
      chk("t2_data_rdata", data_rdata, 32'h1122_3344);
      nxt(); rvalid = 1'b0; inst_req = 1'b0; arready = 1'b1; #1;
      chk("t2_ar_inst", {arvalid, arid}, {1'b1, IID});
      chk("t2_araddr_inst", araddr, 32'hBFC0_0010);
      nxt(); arready = 1'b0; rvalid = 1'b1; rid = IID; rdata = 32'hCAFE_F00D; #1;
      chk("t2_inst_resp", {inst_rvalid, data_rvalid}, 2'b10);
      nxt(); rvalid = 1'b0;

      // Flush after grant: transaction completes, response suppressed
      nxt(); inst_req = 1'b1; inst_addr = 32'hBFC0_0020; #1;
      chk("t3_gnt", inst_gnt, 1);
      nxt(); inst_req = 1'b0; flush = 1'b1; arready = 1'b1; #1;
      chk("t3_ar_held", arvalid, 1);
      nxt(); flush = 1'b0; arready = 1'b0; #1;
      chk("t3_wait", {arvalid, rready}, 2'b01);
      nxt();
      nxt(); rvalid = 1'b1; rid = IID; rdata = 32'hDEAD_BEEF; #1;
      chk("t3_drop", {rready, inst_rvalid, data_rvalid}, 3'b100);
      nxt(); rvalid = 1'b0; #1;
      chk("t3_idle", {arvalid, rready}, 0);
      nxt(); inst_req = 1'b1; inst_addr = 32'hBFC0_0030; #1;
      chk("t3_regnt", inst_gnt, 1);
      nxt(); inst_req = 1'b0; arready = 1'b1;
      nxt(); arready = 1'b0; rvalid = 1'b1; rid = IID; rdata = 32'h0000_1234; #1;
      chk("t3_after_drop", inst_rvalid, 1);
      nxt(); rvalid = 1'b0;

      // Store wins over simultaneous load; load waits until data_bvalid
      nxt(); data_wen = 1'b1; data_ren = 1'b1; data_addr = 32'h8000_1000;
      data_wdata = 32'hA5A5_1234; data_wsel = 4'b0011; #1;
      chk("t4_gnt", {data_gnt, inst_gnt}, 2'b10);
      nxt(); data_wen = 1'b0; data_addr = 32'h8000_2000; awready = 1'b1; #1;
      chk("t4_aw", {awvalid, wvalid, arvalid, data_gnt}, 4'b1100);
      chk("t4_awaddr", awaddr, 32'h8000_1000);
      chk("t4_wdata", wdata, 32'hA5A5_1234);
      chk("t4_wstrb", wstrb, 4'h3);
      chk("t4_ids", {awid, wid}, 8'h11);
      nxt(); awready = 1'b0; wready = 1'b1; #1;
      chk("t4_w", {awvalid, wvalid, data_gnt}, 3'b010);
      nxt(); wready = 1'b0; #1;
      chk("t4_resp", {awvalid, wvalid, bready, data_gnt, data_bvalid}, 5'b00100);
      nxt(); bvalid = 1'b1; #1;
      chk("t4_b", {data_bvalid, data_gnt}, 2'b10);
      nxt(); bvalid = 1'b0; #1;
      chk("t5_load_gnt", {data_gnt, data_bvalid}, 2'b10);
      nxt(); data_ren = 1'b0; arready = 1'b1; #1;
      chk("t5_ar", {arvalid, arid}, {1'b1, DID});
      chk("t5_araddr", araddr, 32'h8000_2000);
      nxt(); arready = 1'b0; rvalid = 1'b1; rid = DID; rdata = 32'h5555_AAAA; #1;
      chk("t5_resp", {data_rvalid, inst_rvalid}, 2'b10);
      nxt(); rvalid = 1'b0;

      // Asynchronous reset in R_AR
      nxt(); inst_req = 1'b1; inst_addr = 32'hBFC0_0040; #1;
      chk("t6_gnt", inst_gnt, 1);
      nxt(); inst_req = 1'b0; #1;
      chk("t6_ar", arvalid, 1);
      #1; aresetn = 1'b0; #1;
      chk("t6_rst_now", {arvalid, rready}, 0);
      nxt(); nxt(); aresetn = 1'b1;
      nxt(); inst_req = 1'b1; inst_addr = 32'hBFC0_0050; #1;
      chk("t6_regnt", inst_gnt, 1);
      nxt(); inst_req = 1'b0; arready = 1'b1; #1;
      chk("t6_ar2", {arvalid, araddr}, {1'b1, 32'hBFC0_0050});
      nxt(); arready = 1'b0; rvalid = 1'b1; rid = IID; rdata = 32'h0BAD_F00D; #1;
      chk("t6_resp", {inst_rvalid, inst_rdata}, {1'b1, 32'h0BAD_F00D});
      nxt(); rvalid = 1'b0;

      // Randomized traffic
      rd_v = 0; rd_ar = 0; rd_drop = 0; rd_id = '0; rd_addr = '0;
      st_v = 0; st_aw = 0; st_w = 0; st_addr = '0; st_data = '0; st_strb = '0;
      inst_clr = 0; data_clr = 0;
      for (int c = 0; c < 4000; c++) begin
         gen = (c < 3500);
         nxt();
         if (inst_clr) begin inst_req = 1'b0; inst_clr = 1'b0; end
         if (data_clr) begin data_ren = 1'b0; data_wen = 1'b0; data_clr = 1'b0; end
         if (gen && !inst_req && $urandom_range(2) == 0) begin
            inst_req  = 1'b1;
            inst_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (gen && !data_ren && !data_wen && $urandom_range(2) == 0) begin
            if ($urandom_range(1) == 1) data_wen = 1'b1;
            else                        data_ren = 1'b1;
            data_addr  = $urandom & 32'hFFFF_FFFC;
            data_wdata = $urandom;
            data_wsel  = 4'($urandom_range(15, 1));
         end
         flush   = gen && ($urandom_range(7) == 0);
         arready = 1'($urandom_range(1));
         awready = 1'($urandom_range(1));
         wready  = 1'($urandom_range(1));
         rvalid  = rd_v && rd_ar && ($urandom_range(1) == 1);
         rid     = rd_id;
         rdata   = $urandom;
         bvalid  = st_v && st_aw && st_w && ($urandom_range(1) == 1);
         #1;
         chk("r_arvalid", arvalid, rd_v && !rd_ar);
         chk("r_rready", rready, rd_v && rd_ar);
         chk("r_inst_rvalid", inst_rvalid, rvalid && rd_id == IID && !rd_drop);
         chk("r_data_rvalid", data_rvalid, rvalid && rd_id == DID);
         chk("w_awvalid", awvalid, st_v && !st_aw);
         chk("w_wvalid", wvalid, st_v && !st_w);
         chk("w_bready", bready, st_v && st_aw && st_w);
         chk("w_bvalid_out", data_bvalid, bvalid);
         if (inst_rvalid) chk("r_inst_rdata", inst_rdata, rdata);
         if (data_rvalid) chk("r_data_rdata", data_rdata, rdata);
         if (arvalid && arready) begin
            chk("r_araddr", araddr, rd_addr);
            chk("r_arid", arid, rd_id);
            rd_ar = 1'b1;
         end
         if (awvalid && awready) begin
            chk("w_awaddr", awaddr, st_addr);
            st_aw = 1'b1;
         end
         if (wvalid && wready) begin
            chk("w_wdata", wdata, st_data);
            chk("w_wstrb", wstrb, st_strb);
            st_w = 1'b1;
         end
         rd_done      = rvalid && rd_v && rd_ar;
         rd_free      = !rd_v || rd_done;
         st_busy      = st_v;
         rd_busy_data = rd_v && rd_id == DID;
         load_ok      = data_ren && !data_wen && !st_busy;
         if (rd_done) rd_v = 1'b0;
         if (flush && rd_v && rd_id == IID) rd_drop = 1'b1;
         if (bvalid) st_v = 1'b0;
         if (inst_gnt) begin
            chk("g_inst", {inst_req, flush, rd_free, load_ok}, 4'b1010);
            rd_v = 1'b1; rd_ar = 1'b0; rd_drop = 1'b0; rd_id = IID; rd_addr = inst_addr;
            inst_clr = 1'b1;
         end
         if (data_gnt) begin
            chk("g_data_req", data_ren || data_wen, 1);
            if (data_wen) begin
               chk("g_store", {st_busy, rd_busy_data}, 2'b00);
               st_v = 1'b1; st_aw = 1'b0; st_w = 1'b0;
               st_addr = data_addr; st_data = data_wdata; st_strb = data_wsel;
            end else begin
               chk("g_load", {rd_free, st_busy, inst_gnt}, 3'b100);
               rd_v = 1'b1; rd_ar = 1'b0; rd_drop = 1'b0; rd_id = DID; rd_addr = data_addr;
            end
            data_clr = 1'b1;
         end
      end
      nxt();
      if (inst_clr) inst_req = 1'b0;
      if (data_clr) begin data_ren = 1'b0; data_wen = 1'b0; end
      #1;
      chk("drain", {rd_v, st_v, inst_req, data_ren, data_wen, arvalid, awvalid, wvalid, rready, bready}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
